// File: rtl/transducer_array_ctrl.sv
// rtl/transducer_array_ctrl.sv - phased square-wave transducer driver with byte command parser
module transducer_array_ctrl #(
  parameter int NUM_CHANNELS = 8,
  parameter int CNT_MAX      = 256,
  parameter int MASTER       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  input  logic                    sync_in,
  output logic                    sync_out,
  output logic [NUM_CHANNELS-1:0] trans,
  output logic                    frame_error,
  output logic                    commit_done
);

  localparam int PHASE_W = $clog2(CNT_MAX);

  typedef enum logic [1:0] {HDR, PAYLOAD, COMMIT_WAIT} state_t;

  state_t                   state;
  logic [PHASE_W-1:0]       cnt;
  logic [PHASE_W-1:0]       cnt_next;
  logic                     sync_meta;
  logic                     sync_s;
  logic                     sync_d;
  logic                     realign;
  logic                     take;
  logic [4:0]               chan;
  logic                     is_en;
  logic [PHASE_W-1:0]       ph_sh  [NUM_CHANNELS];
  logic [PHASE_W-1:0]       ph_act [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  en_sh;
  logic [NUM_CHANNELS-1:0]  en_act;
  logic [NUM_CHANNELS-1:0]  trans_next;

  // The parser stalls the host only while a commit waits for the period boundary
  assign rx_ready = (state != COMMIT_WAIT);
  assign take     = rx_valid && rx_ready;

  // A slave realigns on a rising edge of the synchronized reference; a master never does
  assign realign  = (MASTER == 0) && sync_s && !sync_d;

  // Realign and natural wrap both land on zero, so a coincident edge yields a single boundary
  assign cnt_next = realign ? '0 : cnt + PHASE_W'(1);

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
      sync_d    <= 1'b0;
    end else begin
      sync_meta <= sync_in;
      sync_s    <= sync_meta;
      sync_d    <= sync_s;
    end
  end

  // Period counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_next;
  end

  // Channel is high for the half period starting at its phase; the MSB of the
  // wrapped difference is clear exactly when the difference is below CNT_MAX/2
  always_comb begin
    logic [PHASE_W-1:0] diff;
    diff       = '0;
    trans_next = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      diff          = cnt - ph_act[i];
      trans_next[i] = en_act[i] && !diff[PHASE_W-1];
    end
  end

  // Registered drive outputs; the master reference tracks the counter value it is loading
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trans    <= '0;
      sync_out <= 1'b0;
    end else begin
      trans    <= trans_next;
      sync_out <= (MASTER != 0) ? !cnt_next[PHASE_W-1] : sync_s;
    end
  end

  // Command parser with shadow registers, applied to the active set at a period boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HDR;
      chan        <= '0;
      is_en       <= 1'b0;
      frame_error <= 1'b0;
      commit_done <= 1'b0;
      en_sh       <= '0;
      en_act      <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        ph_sh[i]  <= '0;
        ph_act[i] <= '0;
      end
    end else begin
      frame_error <= 1'b0;
      commit_done <= 1'b0;
      case (state)
        HDR: begin
          if (take) begin
            if (rx_data == 8'hFF) begin
              state <= COMMIT_WAIT;
            end else if (rx_data[7:6] == 2'b10) begin
              chan  <= rx_data[4:0];
              is_en <= rx_data[5];
              state <= PAYLOAD;
            end else begin
              frame_error <= 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (take) begin
            state <= HDR;
            if (int'(chan) >= NUM_CHANNELS) frame_error <= 1'b1;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
              if (chan == 5'(i)) begin
                if (is_en) en_sh[i] <= rx_data[0];
                else       ph_sh[i] <= rx_data[PHASE_W-1:0];
              end
            end
          end
        end
        COMMIT_WAIT: begin
          if (cnt_next == '0) begin
            en_act      <= en_sh;
            for (int i = 0; i < NUM_CHANNELS; i++) ph_act[i] <= ph_sh[i];
            commit_done <= 1'b1;
            state       <= HDR;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_transducer_array_ctrl.sv
// tb/tb_transducer_array_ctrl.sv - directed self-checking bench for transducer_array_ctrl
module tb_transducer_array_ctrl;

  localparam int N  = 8;
  localparam int CM = 256;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic         sync_in_m = 1'b0;
  logic         sync_out;
  logic [N-1:0] trans;
  logic         frame_error;
  logic         commit_done;
  logic [7:0]   s_rx_data = '0;
  logic         s_rx_valid = 1'b0;
  logic         s_rx_ready;
  logic         sync_in_s = 1'b0;
  logic         s_sync_out;
  logic [N-1:0] s_trans;
  logic         s_frame_error;
  logic         s_commit_done;

  int errors = 0;
  int checks = 0;
  int m_cnt;
  int fe_cnt = 0;
  int sc_cnt = 0;

  transducer_array_ctrl #(.NUM_CHANNELS(N), .CNT_MAX(CM), .MASTER(1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .sync_in(sync_in_m), .sync_out(sync_out), .trans(trans),
    .frame_error(frame_error), .commit_done(commit_done)
  );

  transducer_array_ctrl #(.NUM_CHANNELS(N), .CNT_MAX(CM), .MASTER(0)) dut_s (
    .clk(clk), .rst(rst), .rx_data(s_rx_data), .rx_valid(s_rx_valid), .rx_ready(s_rx_ready),
    .sync_in(sync_in_s), .sync_out(s_sync_out), .trans(s_trans),
    .frame_error(s_frame_error), .commit_done(s_commit_done)
  );

  always #5 clk = ~clk;

  // Reference period counter for the master
  always @(posedge clk or posedge rst) begin
    if (rst) m_cnt <= 0;
    else     m_cnt <= (m_cnt + 1) % CM;
  end

  // Pulse counters
  always @(negedge clk) begin
    if (frame_error === 1'b1)   fe_cnt++;
    if (s_commit_done === 1'b1) sc_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic send(input bit s, input logic [7:0] b);
    int n;
    @(negedge clk);
    if (s) begin s_rx_data = b; s_rx_valid = 1'b1; end
    else   begin rx_data = b;   rx_valid = 1'b1;   end
    n = 0;
    while (!(s ? s_rx_ready : rx_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("send_timeout", 0, 1);
    @(negedge clk);
    rx_valid   = 1'b0;
    s_rx_valid = 1'b0;
  endtask

  task automatic wait_commit(input bit s, output int n);
    n = 0;
    while (!(s ? s_commit_done : commit_done) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("commit_seen", s ? s_commit_done : commit_done, 1);
  endtask

  task automatic wait_cnt_s(input int v);
    int n;
    n = 0;
    while (int'(dut_s.cnt) != v && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("slave_cnt_reach", dut_s.cnt, v);
  endtask

  // One full period of the master output against the reference waveform
  task automatic sweep(input int ph0, input int en0, input int ph1, input int en1, output int bad);
    bad = 0;
    for (int k = 0; k < CM; k++) begin
      int c;
      int p;
      logic [N-1:0] e;
      c = m_cnt;
      p = (c + CM - 1) % CM;
      e = '0;
      e[0] = (en0 != 0) && (((p - ph0 + CM) % CM) < CM / 2);
      e[1] = (en1 != 0) && (((p - ph1 + CM) % CM) < CM / 2);
      if (trans !== e) bad++;
      if (sync_out !== (c < CM / 2)) bad++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int bad;
    int fe0;
    int sc0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_trans", trans, 0);
    check("rst_sync_out", sync_out, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_commit_done", commit_done, 0);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_s_trans", s_trans, 0);
    rst = 1'b0;
    @(negedge clk);
    check("cnt_first_edge", dut.cnt, 1);
    check("sync_out_after_rst", sync_out, 1);

    // Enable ch0, phase 64, then commit
    send(0, 8'hA0); send(0, 8'h01); send(0, 8'h80); send(0, 8'h40);
    n = 0;
    while (m_cnt != 100 && n < 400) begin @(negedge clk); n++; end
    check("pre_commit_trans0", trans[0], 0);
    send(0, 8'hFF);
    wait_commit(0, n);
    check("commit_latency_ok", n <= CM, 1);
    check("apply_at_cnt0", m_cnt, 0);
    sweep(64, 1, 0, 0, bad);
    check("sweep_ph64", bad, 0);

    // Commit backpressure with 0x81 held behind 0xFF
    @(negedge clk); rx_data = 8'hFF; rx_valid = 1'b1;
    @(negedge clk); rx_data = 8'h81;
    bad = 0; n = 0;
    while (!commit_done && n < 300) begin
      if (rx_ready) bad++;
      @(negedge clk);
      n++;
    end
    check("bp_ready_low", bad, 0);
    check("bp_commit_seen", commit_done, 1);
    check("bp_ready_after", rx_ready, 1);
    @(negedge clk); rx_valid = 1'b0;
    send(0, 8'h10);

    // Malformed headers
    fe0 = fe_cnt;
    send(0, 8'h23);
    check("fe_bad_header", frame_error, 1);
    send(0, 8'h9F);
    check("fe_before_payload", frame_error, 0);
    send(0, 8'h10);
    check("fe_out_of_range", frame_error, 1);
    @(negedge clk);
    check("fe_pulse_count", fe_cnt - fe0, 2);
    send(0, 8'hA1); send(0, 8'h01); send(0, 8'hFF);
    wait_commit(0, n);
    sweep(64, 1, 16, 1, bad);
    check("sweep_after_errors", bad, 0);

    // Reset while in PAYLOAD
    n = 0;
    while (trans[0] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    check("trans0_high_before_rst", trans[0], 1);
    send(0, 8'h80);
    #2 rst = 1'b1;
    #1;
    check("midrst_trans", trans, 0);
    check("midrst_sync_out", sync_out, 0);
    check("midrst_rx_ready", rx_ready, 1);
    #1 rst = 1'b0;
    @(negedge clk);
    check("postrst_rx_ready", rx_ready, 1);
    send(0, 8'h05);
    check("fe_after_rst", frame_error, 1);
    send(0, 8'hA0); send(0, 8'h01); send(0, 8'hFF);
    wait_commit(0, n);
    sweep(0, 1, 0, 0, bad);
    check("sweep_ph0_after_rst", bad, 0);

    // Slave realign with a pending commit
    send(1, 8'hA0); send(1, 8'h01);
    wait_cnt_s(10);
    sc0 = sc_cnt;
    send(1, 8'hFF);
    wait_cnt_s(100);
    check("slave_no_early_commit", sc_cnt - sc0, 0);
    sync_in_s = 1'b1;
    @(negedge clk);
    check("realign_e1_cnt", dut_s.cnt, 101);
    check("realign_e1_sync_out", s_sync_out, 0);
    @(negedge clk);
    check("realign_e2_cnt", dut_s.cnt, 102);
    check("realign_e2_commit", s_commit_done, 0);
    @(negedge clk);
    check("realign_e3_cnt", dut_s.cnt, 0);
    check("realign_e3_commit", s_commit_done, 1);
    check("realign_e3_sync_out", s_sync_out, 1);
    @(negedge clk);
    check("realign_trans0", s_trans[0], 1);
    repeat (20) @(negedge clk);
    sync_in_s = 1'b0;
    repeat (280) @(negedge clk);
    check("slave_free_run", dut_s.cnt, 45);
    check("slave_one_commit", sc_cnt - sc0, 1);

    // Sync edge coinciding with natural wrap
    send(1, 8'hFF);
    sc0 = sc_cnt;
    wait_cnt_s(253);
    sync_in_s = 1'b1;
    repeat (3) @(negedge clk);
    check("wrap_sync_cnt0", dut_s.cnt, 0);
    check("wrap_sync_commit", s_commit_done, 1);
    @(negedge clk);
    check("wrap_sync_cnt1", dut_s.cnt, 1);
    check("wrap_sync_one_commit", sc_cnt - sc0, 1);
    sync_in_s = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
